// File: rtl/rob_reg_tracker.sv
// rob_reg_tracker: in-order ROB slice holding rename state per entry; returns PR_old on retire
// and walks younger entries back youngest-first on mispredict, returning each PR_new.
`default_nettype none

module rob_reg_tracker #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4,
  parameter int PR_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_stall,
  input  logic             alloc_valid,
  input  logic             alloc_RegDest,
  input  logic [PR_W-1:0]  alloc_PR_new,
  input  logic [PR_W-1:0]  alloc_PR_old,
  output logic [PTR_W-1:0] alloc_idx,
  input  logic             complete_valid,
  input  logic [PTR_W-1:0] complete_idx,
  input  logic             mispredict,
  input  logic [PTR_W-1:0] mispredict_idx,
  output logic             retire_reg,
  output logic [PR_W-1:0]  PR_old,
  output logic             RegDest_retire,
  output logic             recover,
  output logic [PR_W-1:0]  PR_new_flush,
  output logic             RegDest_ROB,
  output logic             recover_done,
  output logic             full,
  output logic             empty
);

  typedef enum logic [0:0] {
    NORMAL  = 1'b0,
    RECOVER = 1'b1
  } state_t;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  state_t           state_q, state_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] stop_q, stop_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             rdone_q, rdone_d;

  logic             regdest_q [DEPTH];
  logic [PR_W-1:0]  prnew_q   [DEPTH];
  logic [PR_W-1:0]  prold_q   [DEPTH];
  logic [DEPTH-1:0] done_q;

  logic [PTR_W-1:0] tail_m1;
  logic [PTR_W-1:0] mis_stop;
  logic             alloc_go;
  logic             retire_go;

  assign tail_m1        = tail_q - PTR_ONE;
  assign mis_stop       = mispredict_idx + PTR_ONE;
  assign alloc_idx      = tail_q;
  assign full           = (count_q == CNT_FULL);
  assign empty          = (count_q == '0);
  assign recover        = (state_q == RECOVER);
  assign recover_done   = rdone_q;
  assign retire_reg     = (state_q == NORMAL) && !empty && done_q[head_q];
  assign PR_old         = prold_q[head_q];
  assign RegDest_retire = regdest_q[head_q];
  assign PR_new_flush   = recover ? prnew_q[tail_m1] : '0;
  assign RegDest_ROB    = recover ? regdest_q[tail_m1] : 1'b0;

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    stop_d    = stop_q;
    count_d   = count_q;
    rdone_d   = 1'b0;
    alloc_go  = 1'b0;
    retire_go = 1'b0;
    if (!hazard_stall) begin
      case (state_q)
        NORMAL: begin
          retire_go = retire_reg;
          // Dispatch in a mispredict cycle is wrong-path and is dropped.
          alloc_go  = alloc_valid && !full && !mispredict;
          if (retire_go) head_d = head_q + PTR_ONE;
          if (alloc_go)  tail_d = tail_q + PTR_ONE;
          if (alloc_go && !retire_go)      count_d = count_q + CNT_ONE;
          else if (!alloc_go && retire_go) count_d = count_q - CNT_ONE;
          if (mispredict) begin
            stop_d = mis_stop;
            if (mis_stop == tail_q) rdone_d = 1'b1;
            else                    state_d = RECOVER;
          end
        end
        RECOVER: begin
          tail_d  = tail_m1;
          count_d = count_q - CNT_ONE;
          if (tail_m1 == stop_q) begin
            state_d = NORMAL;
            rdone_d = 1'b1;
          end
        end
        default: state_d = NORMAL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NORMAL;
      head_q  <= '0;
      tail_q  <= '0;
      stop_q  <= '0;
      count_q <= '0;
      rdone_q <= 1'b0;
      done_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regdest_q[i] <= 1'b0;
        prnew_q[i]   <= '0;
        prold_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      stop_q  <= stop_d;
      count_q <= count_d;
      rdone_q <= rdone_d;
      // Clears below override a stale completion aimed at a recycled slot.
      if (complete_valid && !hazard_stall) done_q[complete_idx] <= 1'b1;
      if (retire_go) done_q[head_q] <= 1'b0;
      if (alloc_go) begin
        done_q[tail_q]    <= 1'b0;
        regdest_q[tail_q] <= alloc_RegDest;
        prnew_q[tail_q]   <= alloc_PR_new;
        prold_q[tail_q]   <= alloc_PR_old;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rob_reg_tracker.sv
// Self-checking bench for rob_reg_tracker: scoreboard queues hold expected retire/flush streams.
`default_nettype none

module tb_rob_reg_tracker;

  localparam int DEPTH = 16;
  localparam int PTR_W = 4;
  localparam int PR_W  = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             hazard_stall;
  logic             alloc_valid;
  logic             alloc_RegDest;
  logic [PR_W-1:0]  alloc_PR_new;
  logic [PR_W-1:0]  alloc_PR_old;
  logic [PTR_W-1:0] alloc_idx;
  logic             complete_valid;
  logic [PTR_W-1:0] complete_idx;
  logic             mispredict;
  logic [PTR_W-1:0] mispredict_idx;
  logic             retire_reg;
  logic [PR_W-1:0]  PR_old;
  logic             RegDest_retire;
  logic             recover;
  logic [PR_W-1:0]  PR_new_flush;
  logic             RegDest_ROB;
  logic             recover_done;
  logic             full;
  logic             empty;

  int vectors = 0;
  int miscompares = 0;

  logic [PR_W:0] retire_sb[$];
  logic [PR_W:0] flush_sb[$];

  rob_reg_tracker #(.DEPTH(DEPTH), .PTR_W(PTR_W), .PR_W(PR_W)) dut (
    .clk(clk), .rst(rst), .hazard_stall(hazard_stall),
    .alloc_valid(alloc_valid), .alloc_RegDest(alloc_RegDest),
    .alloc_PR_new(alloc_PR_new), .alloc_PR_old(alloc_PR_old), .alloc_idx(alloc_idx),
    .complete_valid(complete_valid), .complete_idx(complete_idx),
    .mispredict(mispredict), .mispredict_idx(mispredict_idx),
    .retire_reg(retire_reg), .PR_old(PR_old), .RegDest_retire(RegDest_retire),
    .recover(recover), .PR_new_flush(PR_new_flush), .RegDest_ROB(RegDest_ROB),
    .recover_done(recover_done), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hazard_stall = 1'b0; alloc_valid = 1'b0; alloc_RegDest = 1'b0;
    alloc_PR_new = '0; alloc_PR_old = '0; complete_valid = 1'b0;
    complete_idx = '0; mispredict = 1'b0; mispredict_idx = '0;
  endtask

  task automatic apply_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_alloc(input logic rd, input logic [PR_W-1:0] pn, input logic [PR_W-1:0] po);
    alloc_valid = 1'b1; alloc_RegDest = rd; alloc_PR_new = pn; alloc_PR_old = po;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic do_complete(input logic [PTR_W-1:0] idx);
    complete_valid = 1'b1; complete_idx = idx;
    tick();
    complete_valid = 1'b0;
  endtask

  // Walks the recovery, comparing each flushed entry against the scoreboard head.
  task automatic run_walk(input bit stall_second, output int walk);
    bit stalled = 1'b0;
    walk = 0;
    for (int c = 0; c < 20; c++) begin
      if (!recover) break;
      hazard_stall = stall_second && (walk == 1) && !stalled;
      if (hazard_stall) stalled = 1'b1;
      vectors++;
      if (flush_sb.size() == 0) begin
        miscompares++;
        $display("FAIL walk_extra got=%0d exp=none", PR_new_flush);
      end else begin
        if ({RegDest_ROB, PR_new_flush} !== flush_sb[0]) begin
          miscompares++;
          $display("FAIL walk_flush step=%0d got=%0h exp=%0h", walk, {RegDest_ROB, PR_new_flush}, flush_sb[0]);
        end
        if (!hazard_stall) void'(flush_sb.pop_front());
      end
      walk++;
      tick();
      hazard_stall = 1'b0;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got=%0b exp=0", full); end
    vectors++; if (retire_reg !== 1'b0) begin miscompares++; $display("FAIL reset_retire got=%0b exp=0", retire_reg); end
    vectors++; if (recover !== 1'b0) begin miscompares++; $display("FAIL reset_recover got=%0b exp=0", recover); end
    vectors++; if (recover_done !== 1'b0) begin miscompares++; $display("FAIL reset_rdone got=%0b exp=0", recover_done); end
    vectors++; if (alloc_idx !== 4'd0) begin miscompares++; $display("FAIL reset_alloc_idx got=%0d exp=0", alloc_idx); end
    vectors++; if (PR_old !== 6'd0) begin miscompares++; $display("FAIL reset_PR_old got=%0d exp=0", PR_old); end
  endtask

  task automatic test_retire();
    logic [PR_W-1:0] pn [3] = '{6'd32, 6'd33, 6'd34};
    logic [PR_W-1:0] po [3] = '{6'd5, 6'd6, 6'd7};
    logic            rd [3] = '{1'b1, 1'b0, 1'b1};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (alloc_idx !== PTR_W'(i)) begin miscompares++; $display("FAIL retire_alloc_idx got=%0d exp=%0d", alloc_idx, i); end
      do_alloc(rd[i], pn[i], po[i]);
    end
    do_complete(4'd1);
    vectors++; if (retire_reg !== 1'b0) begin miscompares++; $display("FAIL retire_out_of_order got=%0b exp=0", retire_reg); end
    do_complete(4'd0);
    retire_sb.push_back({1'b1, 6'd5});
    retire_sb.push_back({1'b0, 6'd6});
    for (int c = 0; c < 10 && retire_sb.size() != 0; c++) begin
      if (retire_reg) begin
        vectors++;
        if ({RegDest_retire, PR_old} !== retire_sb[0]) begin
          miscompares++;
          $display("FAIL retire_stream got=%0h exp=%0h", {RegDest_retire, PR_old}, retire_sb[0]);
        end
        void'(retire_sb.pop_front());
      end
      tick();
    end
    vectors++; if (retire_sb.size() != 0) begin miscompares++; $display("FAIL retire_timeout got=%0d exp=0 pending", retire_sb.size()); end
    vectors++; if (retire_reg !== 1'b0) begin miscompares++; $display("FAIL retire_stop got=%0b exp=0", retire_reg); end
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) do_alloc(1'b1, PR_W'(i), 6'd0);
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL full_set got=%0b exp=1", full); end
    do_alloc(1'b1, 6'd63, 6'd63);
    vectors++; if (alloc_idx !== 4'd0) begin miscompares++; $display("FAIL full_drop_tail got=%0d exp=0", alloc_idx); end
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL full_drop_full got=%0b exp=1", full); end
    do_complete(4'd0);
    vectors++; if (retire_reg !== 1'b1) begin miscompares++; $display("FAIL full_retire got=%0b exp=1", retire_reg); end
    tick();
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL full_clear got=%0b exp=0", full); end
    vectors++; if (alloc_idx !== 4'd0) begin miscompares++; $display("FAIL full_next_idx got=%0d exp=0", alloc_idx); end
    do_alloc(1'b1, 6'd20, 6'd21);
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL full_refill got=%0b exp=1", full); end
  endtask

  task automatic test_recover(input bit stall_second);
    int walk;
    apply_reset();
    for (int i = 0; i < 5; i++) do_alloc(1'b1, PR_W'(40 + i), PR_W'(i));
    flush_sb.delete();
    flush_sb.push_back({1'b1, 6'd44});
    flush_sb.push_back({1'b1, 6'd43});
    flush_sb.push_back({1'b1, 6'd42});
    mispredict = 1'b1; mispredict_idx = 4'd1;
    tick();
    mispredict = 1'b0;
    run_walk(stall_second, walk);
    vectors++; if (walk != (stall_second ? 4 : 3)) begin miscompares++; $display("FAIL recover_len got=%0d exp=%0d", walk, stall_second ? 4 : 3); end
    vectors++; if (flush_sb.size() != 0) begin miscompares++; $display("FAIL recover_missing got=%0d exp=0", flush_sb.size()); end
    vectors++; if (recover_done !== 1'b1) begin miscompares++; $display("FAIL recover_done_pulse got=%0b exp=1", recover_done); end
    tick();
    vectors++; if (recover_done !== 1'b0) begin miscompares++; $display("FAIL recover_done_clear got=%0b exp=0", recover_done); end
    vectors++; if (alloc_idx !== 4'd2) begin miscompares++; $display("FAIL recover_tail got=%0d exp=2", alloc_idx); end
  endtask

  task automatic test_wrap();
    int walk;
    apply_reset();
    for (int i = 0; i < 14; i++) do_alloc(1'b0, PR_W'(i), 6'd0);
    for (int i = 0; i < 14; i++) do_complete(PTR_W'(i));
    for (int c = 0; c < 40 && !empty; c++) tick();
    vectors++; if (empty !== 1'b1 || alloc_idx !== 4'd14) begin miscompares++; $display("FAIL wrap_setup got=%0b/%0d exp=1/14", empty, alloc_idx); end
    do_alloc(1'b1, 6'd50, 6'd1);
    do_alloc(1'b0, 6'd51, 6'd2);
    do_alloc(1'b1, 6'd52, 6'd3);
    do_alloc(1'b0, 6'd53, 6'd4);
    flush_sb.delete();
    flush_sb.push_back({1'b0, 6'd53});
    flush_sb.push_back({1'b1, 6'd52});
    flush_sb.push_back({1'b0, 6'd51});
    mispredict = 1'b1; mispredict_idx = 4'd14;
    tick();
    mispredict = 1'b0;
    run_walk(1'b0, walk);
    vectors++; if (walk != 3 || flush_sb.size() != 0) begin miscompares++; $display("FAIL wrap_walk got=%0d/%0d exp=3/0", walk, flush_sb.size()); end
    vectors++; if (alloc_idx !== 4'd15) begin miscompares++; $display("FAIL wrap_tail got=%0d exp=15", alloc_idx); end
    vectors++; if (recover_done !== 1'b1) begin miscompares++; $display("FAIL wrap_rdone got=%0b exp=1", recover_done); end
    // Mispredict on the youngest entry: nothing to flush.
    mispredict = 1'b1; mispredict_idx = 4'd14;
    tick();
    mispredict = 1'b0;
    vectors++; if (recover !== 1'b0) begin miscompares++; $display("FAIL noyoung_recover got=%0b exp=0", recover); end
    vectors++; if (recover_done !== 1'b1) begin miscompares++; $display("FAIL noyoung_rdone got=%0b exp=1", recover_done); end
    tick();
    vectors++; if (recover_done !== 1'b0 || alloc_idx !== 4'd15) begin miscompares++; $display("FAIL noyoung_after got=%0b/%0d exp=0/15", recover_done, alloc_idx); end
  endtask

  task automatic test_reset_walk();
    apply_reset();
    for (int i = 0; i < 5; i++) do_alloc(1'b1, PR_W'(40 + i), PR_W'(i));
    mispredict = 1'b1; mispredict_idx = 4'd1;
    tick();
    mispredict = 1'b0;
    tick();
    vectors++; if (recover !== 1'b1) begin miscompares++; $display("FAIL rstwalk_active got=%0b exp=1", recover); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (recover !== 1'b0) begin miscompares++; $display("FAIL rstwalk_recover got=%0b exp=0", recover); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL rstwalk_empty got=%0b exp=1", empty); end
    vectors++; if (alloc_idx !== 4'd0 || recover_done !== 1'b0) begin miscompares++; $display("FAIL rstwalk_state got=%0d/%0b exp=0/0", alloc_idx, recover_done); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_retire();
    test_full();
    test_recover(1'b0);
    test_recover(1'b1);
    test_wrap();
    test_reset_walk();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
